// File: rtl/gb_apu_frame_sequencer.sv
// gb_apu_frame_sequencer: 512 Hz APU frame sequencer emitting one-cycle length/envelope/sweep strobes.
// Define GB_APU_FS_EXT_DIV_EN to take frame timing from div_bit falling edges instead of the prescaler.
module gb_apu_frame_sequencer #(
  parameter int CLK_DIV = 8192,
  parameter int DIV_W   = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_enable,
  input  logic       div_bit,
  output logic       clk_length_ctr,
  output logic       clk_vol_env,
  output logic       clk_sweep,
  output logic [2:0] step
);

  // Strobe pattern for the executing step, packed as {length, sweep, envelope}.
  function automatic logic [2:0] step_strobes(input logic [2:0] s);
    logic [2:0] r;
    case (s)
      3'd0, 3'd4: r = 3'b100;
      3'd2, 3'd6: r = 3'b110;
      3'd7:       r = 3'b001;
      default:    r = 3'b000;
    endcase
    return r;
  endfunction

  logic       tick_s;
  logic [2:0] step_r;
  logic [2:0] strobe_r;

`ifdef GB_APU_FS_EXT_DIV_EN
  logic             div_q_r;
  logic [DIV_W-1:0] unused_cfg_s;

  assign unused_cfg_s = DIV_W'(CLK_DIV);

  // div_q follows div_bit even while disabled so a stale high cannot fake a falling edge on enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q_r <= 1'b0;
    end else begin
      div_q_r <= div_bit;
    end
  end

  // Frame event on each falling edge of the external divider bit.
  always_comb begin
    tick_s = apu_enable && div_q_r && !div_bit;
  end
`else
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] prescaler_r;
  logic             unused_div_s;

  assign unused_div_s = div_bit;

  // Frame event on the last prescaler count of each frame step.
  always_comb begin
    tick_s = apu_enable && (prescaler_r == DIV_LAST);
  end

  // Prescaler counts enabled clocks and wraps on each frame event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_r <= '0;
    end else if (!apu_enable || tick_s) begin
      prescaler_r <= '0;
    end else begin
      prescaler_r <= prescaler_r + DIV_W'(1);
    end
  end
`endif

  // Step counter and registered strobes; disabling parks at step 0 after any in-flight strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_r   <= 3'd0;
      strobe_r <= 3'b000;
    end else if (!apu_enable) begin
      step_r   <= 3'd0;
      strobe_r <= 3'b000;
    end else if (tick_s) begin
      step_r   <= step_r + 3'd1;
      strobe_r <= step_strobes(step_r);
    end else begin
      strobe_r <= 3'b000;
    end
  end

  assign clk_length_ctr = strobe_r[2];
  assign clk_sweep      = strobe_r[1];
  assign clk_vol_env    = strobe_r[0];
  assign step           = step_r;

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// Directed self-checking bench for gb_apu_frame_sequencer (CLK_DIV=4 instance plus a full-rate instance).
// Observation convention: "edge n" is the n-th rising edge with apu_enable high; outputs sampled 1 ns after it.
module tb_gb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       en_big = 1'b0;
  logic       div_bit = 1'b0;
  logic       len, env, sw;
  logic [2:0] stp;
  logic       len_b, env_b, sw_b;
  logic [2:0] stp_b;
  int         n_pass = 0;
  int         n_total = 0;

  // Hand-written step tables, bit i = strobe issued when step i executes.
  localparam logic [7:0] LEN_TAB = 8'b0101_0101;
  localparam logic [7:0] SWP_TAB = 8'b0100_0100;
  localparam logic [7:0] ENV_TAB = 8'b1000_0000;

  gb_apu_frame_sequencer #(.CLK_DIV(4), .DIV_W(3)) dut (
    .clk(clk), .reset(reset), .apu_enable(en), .div_bit(div_bit),
    .clk_length_ctr(len), .clk_vol_env(env), .clk_sweep(sw), .step(stp)
  );

  gb_apu_frame_sequencer dut_big (
    .clk(clk), .reset(reset), .apu_enable(en_big), .div_bit(div_bit),
    .clk_length_ctr(len_b), .clk_vol_env(env_b), .clk_sweep(sw_b), .step(stp_b)
  );

  always #5 clk = ~clk;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    en_big = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({len, sw, env, stp, len_b, sw_b, env_b, stp_b} !== 12'd0) begin
      $display("FAIL reset_async: got %b %b %b %0d / %b %b %b %0d, want all 0",
               len, sw, env, stp, len_b, sw_b, env_b, stp_b);
    end else n_pass++;
    edge1();
    n_total++;
    if ({len, sw, env, stp, len_b, sw_b, env_b, stp_b} !== 12'd0) begin
      $display("FAIL reset_held: got %b %b %b %0d / %b %b %b %0d, want all 0",
               len, sw, env, stp, len_b, sw_b, env_b, stp_b);
    end else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_sequence();
    logic [2:0] exp_str;
    logic [2:0] exp_step;
    int s;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      edge1();
      exp_str = 3'b000;
      if (n % 4 == 0) begin
        s = (n / 4 - 1) % 8;
        exp_str = {LEN_TAB[s], SWP_TAB[s], ENV_TAB[s]};
      end
      exp_step = 3'((n / 4) % 8);
      n_total++;
      if ({len, sw, env} !== exp_str || stp !== exp_step) begin
        $display("FAIL sequence edge=%0d: got LSE=%b step=%0d, want LSE=%b step=%0d",
                 n, {len, sw, env}, stp, exp_str, exp_step);
      end else n_pass++;
    end
  endtask

  task automatic test_counts();
    int c_len, c_sw, c_env;
    logic [2:0] prev;
    logic wide;
    c_len = 0; c_sw = 0; c_env = 0; prev = 3'b000; wide = 1'b0;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      edge1();
      if (len) c_len++;
      if (sw) c_sw++;
      if (env) c_env++;
      if ((prev & {len, sw, env}) != 3'b000) wide = 1'b1;
      prev = {len, sw, env};
    end
    n_total++;
    if (c_len !== 8) $display("FAIL count_len: got %0d, want 8", c_len); else n_pass++;
    n_total++;
    if (c_sw !== 4) $display("FAIL count_sweep: got %0d, want 4", c_sw); else n_pass++;
    n_total++;
    if (c_env !== 2) $display("FAIL count_env: got %0d, want 2", c_env); else n_pass++;
    n_total++;
    if (wide !== 1'b0) $display("FAIL strobe_width: got wide=%b, want 0", wide); else n_pass++;
  endtask

  task automatic test_disable();
    logic [2:0] exp_str;
    logic [2:0] exp_step;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 12; n++) edge1();
    n_total++;
    if ({len, sw, env} !== 3'b110 || stp !== 3'd3) begin
      $display("FAIL pre_disable: got LSE=%b step=%0d, want LSE=110 step=3", {len, sw, env}, stp);
    end else n_pass++;
    en = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      edge1();
      n_total++;
      if ({len, sw, env} !== 3'b000 || stp !== 3'd0) begin
        $display("FAIL disabled cyc=%0d: got LSE=%b step=%0d, want LSE=000 step=0",
                 n, {len, sw, env}, stp);
      end else n_pass++;
    end
    en = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      edge1();
      exp_str  = (n == 4) ? 3'b100 : 3'b000;
      exp_step = (n == 4) ? 3'd1 : 3'd0;
      n_total++;
      if ({len, sw, env} !== exp_str || stp !== exp_step) begin
        $display("FAIL reenable edge=%0d: got LSE=%b step=%0d, want LSE=%b step=%0d",
                 n, {len, sw, env}, stp, exp_str, exp_step);
      end else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] exp_str;
    logic [2:0] exp_step;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 22; n++) edge1();
    n_total++;
    if (stp !== 3'd5) $display("FAIL pre_reset_step: got %0d, want 5", stp); else n_pass++;
    #1;
    reset = 1'b1;
    #1;
    n_total++;
    if ({len, sw, env} !== 3'b000 || stp !== 3'd0) begin
      $display("FAIL async_reset: got LSE=%b step=%0d, want LSE=000 step=0", {len, sw, env}, stp);
    end else n_pass++;
    #1;
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      edge1();
      exp_str  = (n == 4) ? 3'b100 : 3'b000;
      exp_step = (n == 4) ? 3'd1 : 3'd0;
      n_total++;
      if ({len, sw, env} !== exp_str || stp !== exp_step) begin
        $display("FAIL post_reset edge=%0d: got LSE=%b step=%0d, want LSE=%b step=%0d",
                 n, {len, sw, env}, stp, exp_str, exp_step);
      end else n_pass++;
    end
  endtask

  task automatic test_full_rate();
    int first_len, first_env, c_len, c_sw;
    first_len = 0; first_env = 0; c_len = 0; c_sw = 0;
    do_reset();
    en_big = 1'b1;
    for (int n = 1; n <= 70000; n++) begin
      edge1();
      if (len_b) c_len++;
      if (sw_b) c_sw++;
      if (len_b && first_len == 0) first_len = n;
      if (env_b && first_env == 0) begin
        first_env = n;
        break;
      end
    end
    n_total++;
    if (first_len !== 8192) $display("FAIL full_first_len: got %0d, want 8192", first_len); else n_pass++;
    n_total++;
    if (first_env !== 65536) $display("FAIL full_first_env: got %0d, want 65536", first_env); else n_pass++;
    n_total++;
    if (stp_b !== 3'd0) $display("FAIL full_step_wrap: got %0d, want 0", stp_b); else n_pass++;
    n_total++;
    if (c_len !== 4 || c_sw !== 2) begin
      $display("FAIL full_counts: got len=%0d sweep=%0d, want len=4 sweep=2", c_len, c_sw);
    end else n_pass++;
    en_big = 1'b0;
  endtask

  task automatic test_ext_div();
    logic [2:0] exp_str;
    div_bit = 1'b0;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      div_bit = 1'b1;
      for (int i = 0; i < 3; i++) begin
        edge1();
        n_total++;
        if ({len, sw, env} !== 3'b000 || stp !== 3'(k)) begin
          $display("FAIL ext_high k=%0d: got LSE=%b step=%0d, want LSE=000 step=%0d",
                   k, {len, sw, env}, stp, k);
        end else n_pass++;
      end
      div_bit = 1'b0;
      edge1();
      exp_str = {LEN_TAB[k], SWP_TAB[k], ENV_TAB[k]};
      n_total++;
      if ({len, sw, env} !== exp_str || stp !== 3'((k + 1) % 8)) begin
        $display("FAIL ext_tick k=%0d: got LSE=%b step=%0d, want LSE=%b step=%0d",
                 k, {len, sw, env}, stp, exp_str, (k + 1) % 8);
      end else n_pass++;
      for (int i = 0; i < 2; i++) begin
        edge1();
        n_total++;
        if ({len, sw, env} !== 3'b000) begin
          $display("FAIL ext_low k=%0d: got LSE=%b, want 000", k, {len, sw, env});
        end else n_pass++;
      end
    end
    en = 1'b0;
    edge1();
    div_bit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) div_bit = 1'b0;
      edge1();
      n_total++;
      if ({len, sw, env} !== 3'b000 || stp !== 3'd0) begin
        $display("FAIL ext_disabled cyc=%0d: got LSE=%b step=%0d, want LSE=000 step=0",
                 i, {len, sw, env}, stp);
      end else n_pass++;
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      n_total++;
      if ({len, sw, env} !== 3'b000 || stp !== 3'd0) begin
        $display("FAIL ext_reenable cyc=%0d: got LSE=%b step=%0d, want LSE=000 step=0",
                 i, {len, sw, env}, stp);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
`ifdef GB_APU_FS_EXT_DIV_EN
    test_ext_div();
`else
    test_sequence();
    test_counts();
    test_disable();
    test_async_reset();
    test_full_rate();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
